// File: rtl/gpp16_mem_arbiter_if.sv
// rtl/gpp16_mem_arbiter_if.sv - core-side request/response and memory-side bus of the GPP16 arbiter
interface gpp16_mem_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/gpp16_mem_arbiter.sv
// rtl/gpp16_mem_arbiter.sv - data-over-fetch arbiter for the shared GPP16 single-port RAM
// Optional saturating grant counters are built when GPP16_ARB_STATS_EN is defined.
module gpp16_mem_arbiter #(
  parameter int AW         = 16,
  parameter int DW         = 16,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic               clk,
  input  logic               rst,
  gpp16_mem_arbiter_if.slave bus
`ifdef GPP16_ARB_STATS_EN
  ,
  output logic [15:0]        stat_if_cnt,
  output logic [15:0]        stat_d_cnt
`endif
);

  typedef enum logic {S_IDLE, S_WAIT} state_e;
  typedef enum logic {OWN_FETCH, OWN_DATA} owner_e;

  localparam logic [2:0] LAT_INIT   = 3'(MEM_LAT - 1);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_e        state_q, state_d;
  owner_e        owner_q, owner_d;
  logic [2:0]    lat_q, lat_d;
  logic [3:0]    starve_q, starve_d;
  logic          read_done, arb_en, fetch_win, data_win, data_wr;
  logic [AW-1:0] gnt_addr;
  logic [DW-1:0] rd_data;

  // The last WAIT cycle delivers read data and may already issue the next grant.
  assign read_done = (state_q == S_WAIT) && (lat_q == 3'd0);
  assign arb_en    = !rst && ((state_q == S_IDLE) || read_done);
  assign fetch_win = arb_en && bus.if_req && (!bus.d_req || (starve_q == STARVE_LIM));
  assign data_win  = arb_en && bus.d_req && !fetch_win;
  assign data_wr   = data_win && bus.d_we;
  assign gnt_addr  = fetch_win ? bus.if_addr : (data_win ? bus.d_addr : '0);
  assign rd_data   = (!rst && read_done) ? bus.mem_rdata : '0;

  assign bus.if_gnt    = fetch_win;
  assign bus.d_gnt     = data_win;
  assign bus.mem_en    = fetch_win || data_win;
  assign bus.mem_we    = data_wr;
  assign bus.mem_addr  = gnt_addr;
  assign bus.mem_wdata = data_wr ? bus.d_wdata : '0;
  assign bus.if_rvalid = !rst && read_done && (owner_q == OWN_FETCH);
  assign bus.d_rvalid  = !rst && read_done && (owner_q == OWN_DATA);
  assign bus.if_rdata  = (owner_q == OWN_FETCH) ? rd_data : '0;
  assign bus.d_rdata   = (owner_q == OWN_DATA) ? rd_data : '0;

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    lat_d    = lat_q;
    starve_d = starve_q;

    if (state_q == S_WAIT) begin
      if (read_done) state_d = S_IDLE;
      else           lat_d   = lat_q - 3'd1;
    end

    if (fetch_win || (data_win && !bus.d_we)) begin
      state_d = S_WAIT;
      lat_d   = LAT_INIT;
      owner_d = fetch_win ? OWN_FETCH : OWN_DATA;
    end

    if (!bus.if_req || fetch_win) begin
      starve_d = '0;
    end else if (data_win && (starve_q != STARVE_LIM)) begin
      starve_d = starve_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      owner_q  <= OWN_FETCH;
      lat_q    <= '0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      lat_q    <= lat_d;
      starve_q <= starve_d;
    end
  end

`ifdef GPP16_ARB_STATS_EN
  logic [15:0] stat_if_q, stat_d_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_if_q <= '0;
      stat_d_q  <= '0;
    end else begin
      if (fetch_win && (stat_if_q != 16'hFFFF)) stat_if_q <= stat_if_q + 16'd1;
      if (data_win && (stat_d_q != 16'hFFFF))   stat_d_q  <= stat_d_q + 16'd1;
    end
  end

  assign stat_if_cnt = stat_if_q;
  assign stat_d_cnt  = stat_d_q;
`endif

endmodule

// File: tb/tb_gpp16_mem_arbiter.sv
// tb/tb_gpp16_mem_arbiter.sv - directed and randomized checks of gpp16_mem_arbiter
module tb_gpp16_mem_arbiter;
  localparam int LAT  = 2;
  localparam int SMAX = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  gpp16_mem_arbiter_if #(.AW(16), .DW(16)) bus();

`ifdef GPP16_ARB_STATS_EN
  logic [15:0] stat_if_cnt, stat_d_cnt;
`endif

  gpp16_mem_arbiter #(.AW(16), .DW(16), .MEM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus.slave)
`ifdef GPP16_ARB_STATS_EN
    ,
    .stat_if_cnt (stat_if_cnt),
    .stat_d_cnt  (stat_d_cnt)
`endif
  );

  // Memory with two-cycle read latency
  logic [15:0] tb_mem  [0:65535];
  logic [15:0] ref_mem [0:65535];
  logic [15:0] rd_p0 = '0;
  logic [15:0] rd_p1 = '0;

  always @(posedge clk) begin
    if (bus.mem_en && bus.mem_we) tb_mem[bus.mem_addr] <= bus.mem_wdata;
    if (bus.mem_en && !bus.mem_we) rd_p0 <= tb_mem[bus.mem_addr];
    rd_p1 <= rd_p0;
  end
  assign bus.mem_rdata = rd_p1;

  typedef struct {
    bit          is_d;
    logic [15:0] data;
    int          due;
  } rsp_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.if_req  = 1'b0;
    bus.if_addr = '0;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_addr  = '0;
    bus.d_wdata = '0;
  endtask

  task automatic set_word(input logic [15:0] a, input logic [15:0] v);
    tb_mem[a]  = v;
    ref_mem[a] = v;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.if_req = 1'b1; bus.if_addr = 16'h0055;
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 16'h0066; bus.d_wdata = 16'h7777;
    tick();
    tick();
    @(negedge clk);
    checks++;
    if ({bus.if_gnt, bus.d_gnt, bus.if_rvalid, bus.d_rvalid, bus.mem_en, bus.mem_we} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 000000",
               {bus.if_gnt, bus.d_gnt, bus.if_rvalid, bus.d_rvalid, bus.mem_en, bus.mem_we});
    end
    checks++;
    if ({bus.if_rdata, bus.d_rdata, bus.mem_addr, bus.mem_wdata} !== 64'h0) begin
      errors++;
      $display("FAIL reset_data: got %h want 0", {bus.if_rdata, bus.d_rdata, bus.mem_addr, bus.mem_wdata});
    end
    idle_inputs();
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_fetch_read();
    set_word(16'h0010, 16'hABCD);
    bus.if_req = 1'b1; bus.if_addr = 16'h0010;
    @(negedge clk);
    checks++;
    if ({bus.if_gnt, bus.d_gnt, bus.mem_en, bus.mem_we, bus.mem_addr} !== {4'b1010, 16'h0010}) begin
      errors++;
      $display("FAIL fetch_grant: got %b %h want 1010 0010",
               {bus.if_gnt, bus.d_gnt, bus.mem_en, bus.mem_we}, bus.mem_addr);
    end
    tick();
    bus.if_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.if_rvalid, bus.d_rvalid, bus.mem_en} !== 3'b000) begin
      errors++;
      $display("FAIL fetch_t1: got %b want 000", {bus.if_rvalid, bus.d_rvalid, bus.mem_en});
    end
    tick();
    @(negedge clk);
    checks++;
    if ({bus.if_rvalid, bus.d_rvalid, bus.if_rdata, bus.d_rdata} !== {2'b10, 16'hABCD, 16'h0}) begin
      errors++;
      $display("FAIL fetch_rvalid: got %b %h %h want 10 abcd 0000",
               {bus.if_rvalid, bus.d_rvalid}, bus.if_rdata, bus.d_rdata);
    end
    tick();
    @(negedge clk);
    checks++;
    if ({bus.if_rvalid, bus.if_rdata} !== 17'h0) begin
      errors++;
      $display("FAIL fetch_t3: got %b %h want 0 0000", bus.if_rvalid, bus.if_rdata);
    end
    tick();
  endtask

  task automatic test_write();
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 16'h0100; bus.d_wdata = 16'h1234;
    @(negedge clk);
    checks++;
    if ({bus.d_gnt, bus.if_gnt, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata} !==
        {4'b1011, 16'h0100, 16'h1234}) begin
      errors++;
      $display("FAIL write1: got %b %h %h want 1011 0100 1234",
               {bus.d_gnt, bus.if_gnt, bus.mem_en, bus.mem_we}, bus.mem_addr, bus.mem_wdata);
    end
    tick();
    bus.d_addr = 16'h0101; bus.d_wdata = 16'h5678;
    @(negedge clk);
    checks++;
    if ({bus.d_gnt, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata} !==
        {3'b111, 16'h0101, 16'h5678}) begin
      errors++;
      $display("FAIL write2_b2b: got %b %h %h want 111 0101 5678",
               {bus.d_gnt, bus.mem_en, bus.mem_we}, bus.mem_addr, bus.mem_wdata);
    end
    tick();
    idle_inputs();
    ref_mem[16'h0100] = 16'h1234;
    ref_mem[16'h0101] = 16'h5678;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if ({bus.d_rvalid, bus.if_rvalid} !== 2'b00) begin
        errors++;
        $display("FAIL write_no_rvalid: cycle %0d got %b want 00", k, {bus.d_rvalid, bus.if_rvalid});
      end
      tick();
    end
    checks++;
    if ({tb_mem[16'h0100], tb_mem[16'h0101]} !== {16'h1234, 16'h5678}) begin
      errors++;
      $display("FAIL write_mem: got %h %h want 1234 5678", tb_mem[16'h0100], tb_mem[16'h0101]);
    end
  endtask

  task automatic test_simultaneous();
    int dg, dr, ig, ir;
    logic [15:0] dv, iv;
    dg = -1; dr = -1; ig = -1; ir = -1; dv = '0; iv = '0;
    set_word(16'h0020, 16'h1111);
    set_word(16'h0200, 16'h2222);
    bus.if_req = 1'b1; bus.if_addr = 16'h0020;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 16'h0200;
    for (int k = 0; k < 7; k++) begin
      bit gi, gd;
      @(negedge clk);
      gi = bus.if_gnt; gd = bus.d_gnt;
      checks++;
      if (gi && gd) begin
        errors++;
        $display("FAIL sim_onehot: cycle %0d both grants high", k);
      end
      if (gd && dg < 0) dg = k;
      if (gi && ig < 0) ig = k;
      if (bus.d_rvalid && dr < 0) begin dr = k; dv = bus.d_rdata; end
      if (bus.if_rvalid && ir < 0) begin ir = k; iv = bus.if_rdata; end
      tick();
      if (gi) bus.if_req = 1'b0;
      if (gd) bus.d_req = 1'b0;
    end
    checks++;
    if ({dg, dr, ig, ir} !== {32'd0, 32'd2, 32'd2, 32'd4}) begin
      errors++;
      $display("FAIL sim_timing: d_gnt@%0d d_rvalid@%0d if_gnt@%0d if_rvalid@%0d want 0 2 2 4", dg, dr, ig, ir);
    end
    checks++;
    if ({dv, iv} !== {16'h2222, 16'h1111}) begin
      errors++;
      $display("FAIL sim_data: got d=%h if=%h want 2222 1111", dv, iv);
    end
    idle_inputs();
  endtask

  task automatic test_starvation();
    int dq[$];
    int ig;
    ig = -1;
    bus.if_req = 1'b1; bus.if_addr = 16'h0030;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 16'h0300;
    for (int k = 0; k < 10; k++) begin
      bit gi;
      @(negedge clk);
      gi = bus.if_gnt;
      if (bus.d_gnt) dq.push_back(k);
      if (gi && ig < 0) ig = k;
      tick();
      if (gi) bus.if_req = 1'b0;
    end
    checks++;
    if (ig != 6) begin
      errors++;
      $display("FAIL starve_if_gnt: got cycle %0d want 6", ig);
    end
    checks++;
    if (dq.size() != 4 || dq[0] != 0 || dq[1] != 2 || dq[2] != 4 || dq[3] != 8) begin
      errors++;
      $display("FAIL starve_d_gnts: got %p want '{0,2,4,8}", dq);
    end
    idle_inputs();
    repeat (4) tick();
  endtask

  task automatic test_reset_mid_read();
    set_word(16'h0040, 16'h4444);
    set_word(16'h0041, 16'h5555);
    bus.if_req = 1'b1; bus.if_addr = 16'h0040;
    @(negedge clk);
    checks++;
    if (bus.if_gnt !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_gnt: got %b want 1", bus.if_gnt);
    end
    tick();
    rst = 1'b1;
    bus.if_req = 1'b1; bus.if_addr = 16'h0041;
    @(negedge clk);
    checks++;
    if ({bus.if_gnt, bus.d_gnt, bus.if_rvalid, bus.d_rvalid, bus.mem_en, bus.mem_we,
         bus.if_rdata, bus.d_rdata, bus.mem_addr, bus.mem_wdata} !== 70'h0) begin
      errors++;
      $display("FAIL rstmid_outputs: got %h want 0",
               {bus.if_gnt, bus.d_gnt, bus.if_rvalid, bus.d_rvalid, bus.mem_en, bus.mem_we,
                bus.if_rdata, bus.d_rdata, bus.mem_addr, bus.mem_wdata});
    end
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.if_rvalid, bus.if_gnt, bus.mem_addr} !== {2'b01, 16'h0041}) begin
      errors++;
      $display("FAIL rstmid_after: got rvalid=%b gnt=%b addr=%h want 0 1 0041",
               bus.if_rvalid, bus.if_gnt, bus.mem_addr);
    end
    tick();
    bus.if_req = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.if_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_t3: got rvalid=%b want 0", bus.if_rvalid);
    end
    tick();
    @(negedge clk);
    checks++;
    if ({bus.if_rvalid, bus.if_rdata} !== {1'b1, 16'h5555}) begin
      errors++;
      $display("FAIL rstmid_newread: got %b %h want 1 5555", bus.if_rvalid, bus.if_rdata);
    end
    tick();
    idle_inputs();
  endtask

`ifdef GPP16_ARB_STATS_EN
  task automatic test_stats();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      int n;
      n = 0;
      if (i < 5) begin bus.if_req = 1'b1; bus.if_addr = 16'(i); end
      else begin bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 16'(16'h0500 + i); bus.d_wdata = 16'(i); end
      @(negedge clk);
      while (!(bus.if_gnt || bus.d_gnt) && n < 10) begin
        @(negedge clk);
        n++;
      end
      checks++;
      if (!(bus.if_gnt || bus.d_gnt)) begin
        errors++;
        $display("FAIL stats_wait: request %0d not granted within 10 cycles", i);
      end
      tick();
      idle_inputs();
    end
    repeat (3) tick();
    @(negedge clk);
    checks++;
    if ({stat_if_cnt, stat_d_cnt} !== {16'd5, 16'd3}) begin
      errors++;
      $display("FAIL stats_count: got if=%0d d=%0d want 5 3", stat_if_cnt, stat_d_cnt);
    end
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({stat_if_cnt, stat_d_cnt} !== 32'h0) begin
      errors++;
      $display("FAIL stats_reset: got if=%0d d=%0d want 0 0", stat_if_cnt, stat_d_cnt);
    end
    tick();
  endtask
`endif

  task automatic test_random();
    localparam int N = 600;
    rsp_t q[$];
    int   busy_until, starve;
    bit   if_served, d_served;
    busy_until = 0; starve = 0; if_served = 0; d_served = 0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < N; k++) begin
      bit   ef, ed, eir, edr;
      logic [15:0] eiv, edv;
      if (if_served) begin bus.if_req = 1'b0; if_served = 0; end
      if (d_served) begin bus.d_req = 1'b0; d_served = 0; end
      if (!bus.if_req && k < N - 10 && $urandom_range(0, 2) == 0) begin
        bus.if_req = 1'b1; bus.if_addr = {8'h00, 8'($urandom)};
      end else if (bus.if_req && $urandom_range(0, 24) == 0) begin
        bus.if_req = 1'b0;
      end
      if (!bus.d_req && k < N - 10 && $urandom_range(0, 1) == 0) begin
        bus.d_req = 1'b1; bus.d_we = 1'($urandom); bus.d_addr = {8'h00, 8'($urandom)};
        bus.d_wdata = 16'($urandom);
      end else if (bus.d_req && $urandom_range(0, 24) == 0) begin
        bus.d_req = 1'b0;
      end

      @(negedge clk);
      ef = (k >= busy_until) && bus.if_req && (!bus.d_req || starve == SMAX);
      ed = (k >= busy_until) && bus.d_req && !ef;
      eir = 0; edr = 0; eiv = '0; edv = '0;
      if (q.size() > 0 && q[0].due == k) begin
        if (q[0].is_d) begin edr = 1; edv = q[0].data; end
        else begin eir = 1; eiv = q[0].data; end
        void'(q.pop_front());
      end
      checks++;
      if ({bus.if_gnt, bus.d_gnt, bus.mem_en} !== {ef, ed, ef | ed}) begin
        errors++;
        $display("FAIL rnd_grant: cycle %0d got %b want %b", k,
                 {bus.if_gnt, bus.d_gnt, bus.mem_en}, {ef, ed, ef | ed});
      end
      checks++;
      if ({bus.if_rvalid, bus.if_rdata, bus.d_rvalid, bus.d_rdata} !== {eir, eiv, edr, edv}) begin
        errors++;
        $display("FAIL rnd_resp: cycle %0d got if=%b/%h d=%b/%h want if=%b/%h d=%b/%h", k,
                 bus.if_rvalid, bus.if_rdata, bus.d_rvalid, bus.d_rdata, eir, eiv, edr, edv);
      end
      if (ef) begin
        checks++;
        if ({bus.mem_we, bus.mem_addr} !== {1'b0, bus.if_addr}) begin
          errors++;
          $display("FAIL rnd_fetch_bus: cycle %0d got we=%b addr=%h want 0 %h", k,
                   bus.mem_we, bus.mem_addr, bus.if_addr);
        end
        q.push_back('{is_d: 1'b0, data: ref_mem[bus.if_addr], due: k + LAT});
        busy_until = k + LAT;
        if_served = 1;
      end
      if (ed) begin
        checks++;
        if ({bus.mem_we, bus.mem_addr} !== {bus.d_we, bus.d_addr} ||
            (bus.d_we && bus.mem_wdata !== bus.d_wdata)) begin
          errors++;
          $display("FAIL rnd_data_bus: cycle %0d got we=%b addr=%h wd=%h want %b %h %h", k,
                   bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.d_we, bus.d_addr, bus.d_wdata);
        end
        if (bus.d_we) begin
          ref_mem[bus.d_addr] = bus.d_wdata;
        end else begin
          q.push_back('{is_d: 1'b1, data: ref_mem[bus.d_addr], due: k + LAT});
          busy_until = k + LAT;
        end
        d_served = 1;
      end
      if (!bus.if_req || ef) starve = 0;
      else if (ed && starve < SMAX) starve = starve + 1;
      tick();
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL rnd_drain: %0d responses never delivered, want 0", q.size());
    end
    idle_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 65536; i++) begin
      tb_mem[i]  = 16'(i * 7 + 3);
      ref_mem[i] = 16'(i * 7 + 3);
    end
    idle_inputs();
    test_reset();
    test_fetch_read();
    test_write();
    test_simultaneous();
    test_starvation();
    test_reset_mid_read();
`ifdef GPP16_ARB_STATS_EN
    test_stats();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
